// File: rtl/imem_load_ctrl_pkg.sv
// Shared types and sizing helpers for the instruction-memory load controller.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

  function automatic int clog2(input int value);
    int r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // A single-byte word still needs a one-bit lane counter.
  function automatic int cnt_width(input int bytes);
    return (clog2(bytes) < 1) ? 1 : clog2(bytes);
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Fetch, byte-stream, load-control and memory-port signals of the load controller.
interface imem_load_ctrl_if #(parameter int MEMORY_WIDTH = 32);

  logic                    load_start;
  logic [31:0]             load_words;
  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    byte_ready;
  logic                    load_busy;
  logic                    load_done;
  logic                    load_error;
  logic [31:0]             fetch_addr;
  logic                    fetch_ready;
  logic [MEMORY_WIDTH-1:0] fetch_data;
  logic [31:0]             mem_addr;
  logic [MEMORY_WIDTH-1:0] mem_write_data;
  logic                    mem_write_enable;
  logic [MEMORY_WIDTH-1:0] mem_read_data;

  modport master (
    input  load_start, load_words, byte_valid, byte_data, fetch_addr, mem_read_data,
    output byte_ready, load_busy, load_done, load_error, fetch_ready, fetch_data,
           mem_addr, mem_write_data, mem_write_enable
  );

  modport slave (
    output load_start, load_words, byte_valid, byte_data, fetch_addr, mem_read_data,
    input  byte_ready, load_busy, load_done, load_error, fetch_ready, fetch_data,
           mem_addr, mem_write_data, mem_write_enable
  );

endinterface

// File: rtl/imem_byte_packer.sv
// Packs a byte stream little-endian into one memory word; lane 0 receives the first byte.
module imem_byte_packer
  import imem_ctrl_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int CNT_W = cnt_width(BYTES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [BYTES*8-1:0] word_out,
  output logic               last_byte
);

  logic [CNT_W-1:0]   byte_cnt;
  logic [BYTES*8-1:0] word_q;

  assign last_byte = (byte_cnt == CNT_W'(BYTES - 1));
  assign word_out  = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (byte_cnt == CNT_W'(i)) word_q[i*8 +: 8] <= byte_in;
      end
      byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Shares the instruction-memory port between fetch reads and a boot loader that
// streams bytes into consecutive words starting at address 0.
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int MEMORY_DEPTH = 1024,
  parameter int MEMORY_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  imem_load_ctrl_if.master bus
);

  localparam int BYTES = bytes_per_word(MEMORY_WIDTH);

  state_t                  state, next_state;
  logic [31:0]             count;
  logic [31:0]             word_idx;
  logic                    error_q;
  logic                    start_ok;
  logic                    last_word;
  logic                    clear;
  logic                    shift_en;
  logic                    last_byte;
  logic [MEMORY_WIDTH-1:0] word_out;

  imem_byte_packer #(.BYTES(BYTES)) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (shift_en),
    .byte_in  (bus.byte_data),
    .word_out (word_out),
    .last_byte(last_byte)
  );

  assign start_ok  = bus.load_start && (bus.load_words != 32'd0) &&
                     (bus.load_words <= 32'(MEMORY_DEPTH));
  assign last_word = (word_idx == count - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      word_idx <= '0;
      error_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.load_start) begin
        if (start_ok) begin
          count    <= bus.load_words;
          word_idx <= '0;
          error_q  <= 1'b0;
        end else begin
          error_q  <= 1'b1;
        end
      end
      if (state == WRITE && !last_word) word_idx <= word_idx + 32'd1;
    end
  end

  // Fetch owns the memory port only in IDLE; otherwise the port follows word_idx.
  always_comb begin
    next_state           = state;
    clear                = 1'b0;
    shift_en             = 1'b0;
    bus.byte_ready       = 1'b0;
    bus.fetch_ready      = 1'b0;
    bus.fetch_data       = '0;
    bus.mem_addr         = word_idx;
    bus.mem_write_enable = 1'b0;
    bus.load_done        = 1'b0;
    case (state)
      IDLE: begin
        bus.fetch_ready = 1'b1;
        bus.fetch_data  = bus.mem_read_data;
        bus.mem_addr    = bus.fetch_addr;
        if (start_ok) begin
          clear      = 1'b1;
          next_state = COLLECT;
        end
      end
      COLLECT: begin
        bus.byte_ready = 1'b1;
        if (bus.byte_valid) begin
          shift_en = 1'b1;
          if (last_byte) next_state = WRITE;
        end
      end
      WRITE: begin
        bus.mem_write_enable = 1'b1;
        clear                = 1'b1;
        next_state           = last_word ? DONE : COLLECT;
      end
      DONE: begin
        bus.load_done = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.load_busy      = (state != IDLE);
  assign bus.load_error     = error_q;
  assign bus.mem_write_data = word_out;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: IDLE pass-through table, hand-written load
// sequences and randomized loads checked against a word-packing reference model.
module tb_imem_load_ctrl;

  localparam int DEPTH = 1024;
  localparam int WIDTH = 32;
  localparam int BYTES = WIDTH / 8;
  localparam int MEMSZ = 64;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    int          acc;
  } wr_t;

  typedef struct {
    logic        start;
    logic [31:0] words;
    logic [31:0] faddr;
    logic        exp_fready;
    logic [31:0] exp_maddr;
    logic [31:0] exp_fdata;
    logic        exp_error;
    logic        exp_busy;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int accepted = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int viol     = 0;
  int wr_base  = 0;
  int src_gap  = 0;
  int gap_left = 0;

  wr_t         wr_q[$];
  logic [7:0]  src_q[$];
  logic [31:0] mem[MEMSZ];

  imem_load_ctrl_if #(.MEMORY_WIDTH(WIDTH)) bus ();

  imem_load_ctrl #(.MEMORY_DEPTH(DEPTH), .MEMORY_WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign bus.mem_read_data = mem[bus.mem_addr[5:0]];

  function automatic logic [31:0] pattern(input int i);
    return 32'hA5A5_0000 + 32'(i * 7);
  endfunction

  // While busy the port must point at the next word to be written, i.e. the number
  // of words already written in this load.
  always @(negedge clk) begin
    if (bus.load_busy && bus.fetch_ready) viol++;
    if (bus.load_busy && !bus.load_done && bus.mem_addr != 32'(wr_q.size() - wr_base)) viol++;
    if (bus.byte_valid && bus.byte_ready) accepted++;
    if (bus.mem_write_enable) begin
      if (bus.fetch_ready) viol++;
      wr_q.push_back('{bus.mem_addr, bus.mem_write_data, cyc, accepted});
      mem[bus.mem_addr[5:0]] = bus.mem_write_data;
    end
    if (bus.load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    logic hs;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    forever begin
      @(negedge clk);
      hs = bus.byte_valid && bus.byte_ready;
      @(posedge clk);
      #1;
      if (hs && src_q.size() > 0) begin
        void'(src_q.pop_front());
        gap_left = src_gap;
      end
      if (gap_left > 0) begin
        bus.byte_valid = 1'b0;
        gap_left--;
      end else if (src_q.size() > 0) begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = src_q[0];
      end else begin
        bus.byte_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [31:0] words, input logic [31:0] faddr);
    @(posedge clk);
    #1;
    bus.load_start = start;
    bus.load_words = words;
    bus.fetch_addr = faddr;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic runLoad(input int n, input byte_q_t bytes, input int gap, input logic [31:0] faddr,
                         input bit mid_start, input bit exact_timing, input string tag);
    wr_t         w;
    int          base, acc_base, d0, c0, budget;
    logic [31:0] expw, canary;
    bit          timed_out;
    base     = wr_q.size();
    wr_base  = base;
    acc_base = accepted;
    d0       = done_cnt;
    canary   = mem[n];
    src_gap  = gap;
    applyStimulus(1'b1, 32'(n), faddr);
    c0 = cyc;
    foreach (bytes[i]) src_q.push_back(bytes[i]);
    budget    = n * BYTES * (gap + 1) + n * 2 + 40;
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      applyStimulus(mid_start && k == 3, 32'd7, faddr + 32'(k));
      @(negedge clk);
      if (done_cnt != d0) begin
        timed_out = 1'b0;
        break;
      end
    end
    checkOutput({tag, " timeout"}, 32'(timed_out), 32'd0);
    checkOutput({tag, " write count"}, 32'(wr_q.size() - base), 32'(n));
    checkOutput({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < n && base + i < wr_q.size(); i++) begin
      w    = wr_q[base + i];
      expw = '0;
      for (int b = 0; b < BYTES; b++) expw = expw | (32'(bytes[i * BYTES + b]) << (8 * b));
      checkOutput({tag, " write addr"}, w.addr, 32'(i));
      checkOutput({tag, " write data"}, w.data, expw);
      checkOutput({tag, " bytes before write"}, 32'(w.acc - acc_base), 32'((i + 1) * BYTES));
      if (exact_timing) checkOutput({tag, " write cycle"}, 32'(w.cyc - c0), 32'((i + 1) * (BYTES + 1)));
    end
    if (exact_timing) checkOutput({tag, " done cycle"}, 32'(done_cyc - c0), 32'(n * (BYTES + 1) + 1));
    checkOutput({tag, " word past end untouched"}, mem[n], canary);
    applyStimulus(1'b0, 32'd0, faddr);
    @(negedge clk);
    checkOutput({tag, " fetch_ready after done"}, 32'(bus.fetch_ready), 32'd1);
    checkOutput({tag, " busy after done"}, 32'(bus.load_busy), 32'd0);
    checkOutput({tag, " load_error"}, 32'(bus.load_error), 32'd0);
    checkOutput({tag, " port ownership"}, 32'(viol), 32'd0);
    viol = 0;
  endtask

  initial begin
    vec_t    vecs[6];
    byte_q_t bq;
    int      base, acc_base, n;
    bit      reached;

    bus.load_start = 1'b0;
    bus.load_words = 32'd0;
    bus.fetch_addr = 32'd0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = pattern(i);

    vecs[0] = '{1'b0, 32'd0,    32'd5,  1'b1, 32'd5,  pattern(5),  1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'd0,    32'd17, 1'b1, 32'd17, pattern(17), 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'd0,    32'd9,  1'b1, 32'd9,  pattern(9),  1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'd1025, 32'd3,  1'b1, 32'd3,  pattern(3),  1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'd0,    32'd40, 1'b1, 32'd40, pattern(40), 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'd1024, 32'd2,  1'b1, 32'd2,  pattern(2),  1'b0, 1'b1};

    #2;
    checkOutput("reset fetch_ready", 32'(bus.fetch_ready), 32'd1);
    checkOutput("reset load_busy", 32'(bus.load_busy), 32'd0);
    checkOutput("reset byte_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("reset mem_write_enable", 32'(bus.mem_write_enable), 32'd0);
    checkOutput("reset load_done", 32'(bus.load_done), 32'd0);
    checkOutput("reset load_error", 32'(bus.load_error), 32'd0);
    #10;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      wr_base = wr_q.size();
      applyStimulus(vecs[i].start, vecs[i].words, vecs[i].faddr);
      @(negedge clk);
      checkOutput($sformatf("vec%0d fetch_ready", i), 32'(bus.fetch_ready), 32'(vecs[i].exp_fready));
      checkOutput($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].exp_maddr);
      checkOutput($sformatf("vec%0d fetch_data", i), bus.fetch_data, vecs[i].exp_fdata);
      applyStimulus(1'b0, 32'd0, vecs[i].faddr);
      @(negedge clk);
      checkOutput($sformatf("vec%0d load_error", i), 32'(bus.load_error), 32'(vecs[i].exp_error));
      checkOutput($sformatf("vec%0d load_busy", i), 32'(bus.load_busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_busy) doReset();
    end
    viol = 0;

    for (int i = 0; i < 8; i++) bq.push_back(8'(8'h11 * (i + 1)));
    runLoad(2, bq, 0, 32'd5, 1'b0, 1'b1, "seq_nogap");
    runLoad(2, bq, 3, 32'd9, 1'b0, 1'b0, "seq_gap");

    applyStimulus(1'b1, 32'd0, 32'd4);
    applyStimulus(1'b0, 32'd0, 32'd4);
    @(negedge clk);
    checkOutput("zero length sets error", 32'(bus.load_error), 32'd1);
    checkOutput("zero length stays idle", 32'(bus.load_busy), 32'd0);
    bq.delete();
    bq.push_back(8'hEF); bq.push_back(8'hBE); bq.push_back(8'hAD); bq.push_back(8'hDE);
    runLoad(1, bq, 0, 32'd6, 1'b0, 1'b1, "error_clear");

    // Abort a load after two bytes; nothing may reach memory.
    base     = wr_q.size();
    wr_base  = base;
    acc_base = accepted;
    src_gap  = 0;
    applyStimulus(1'b1, 32'd2, 32'd12);
    for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      applyStimulus(1'b0, 32'd0, 32'd12);
      @(negedge clk);
      if (accepted - acc_base >= 2) reached = 1'b1;
    end
    checkOutput("abort two bytes reached", 32'(reached), 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd12);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    src_q.delete();
    bus.byte_valid = 1'b0;
    #1;
    checkOutput("abort fetch_ready", 32'(bus.fetch_ready), 32'd1);
    checkOutput("abort load_busy", 32'(bus.load_busy), 32'd0);
    checkOutput("abort mem_addr", bus.mem_addr, 32'd12);
    checkOutput("abort mem_write_enable", 32'(bus.mem_write_enable), 32'd0);
    rst_n = 1'b1;
    checkOutput("abort no write", 32'(wr_q.size() - base), 32'd0);
    viol = 0;
    bq.delete();
    for (int i = 0; i < BYTES; i++) bq.push_back(8'($urandom));
    runLoad(1, bq, 0, 32'd20, 1'b0, 1'b1, "after_abort");

    bq.delete();
    for (int i = 0; i < 2 * BYTES; i++) bq.push_back(8'($urandom));
    runLoad(2, bq, 0, 32'd33, 1'b1, 1'b1, "mid_start");

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 4));
      bq.delete();
      for (int i = 0; i < n * BYTES; i++) bq.push_back(8'($urandom));
      runLoad(n, bq, int'($urandom_range(0, 2)), 32'($urandom_range(0, 63)), 1'b0, 1'b0,
              $sformatf("random%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
